// File: rtl/sfifo_wr_arbiter_if.sv
// Bundle of the producer-side valid/ready lanes and the FIFO write port seen by the arbiter.
// A beat moves on requester i in any cycle where req_valid[i] and req_ready[i] are both high at posedge.
interface sfifo_wr_arbiter_if #(
   parameter int NREQ = 3,
   parameter int DW   = 8,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               fifo_full;
   logic               fifo_write;
   logic [DW-1:0]      fifo_wdata;
   logic [IDW-1:0]     grant_id;
   logic               busy;

   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_write, fifo_wdata, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_write, fifo_wdata, grant_id, busy
   );
endinterface

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with grants capped at BURST beats.
// FSM state, round-robin pointer and beat counter are exported on o_dbg_* for observation.
module sfifo_wr_arbiter #(
   parameter int NREQ  = 3,
   parameter int DW    = 8,
   parameter int BURST = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                CLK,
   input  logic                RST,
   sfifo_wr_arbiter_if.slave   bus,
   output logic [0:0]          o_dbg_state,
   output logic [IDW-1:0]      o_dbg_rr_ptr,
   output logic [3:0]          o_dbg_beat_cnt
);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]     r_state;
   logic [IDW-1:0] r_grant_id;
   logic [IDW-1:0] r_rr_ptr;
   logic [3:0]     r_beat_cnt;

   logic           w_found;
   logic [IDW-1:0] w_sel;
   int             w_idx;
   logic           w_in_grant;
   logic           w_req_v;
   logic           w_write;
   logic [IDW-1:0] w_next_ptr;

   // Walk downward so the candidate closest to r_rr_ptr is the last (winning) assignment.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = (int'(r_rr_ptr) + k) % NREQ;
         if (bus.req_valid[w_idx]) begin
            w_found = 1'b1;
            w_sel   = IDW'(w_idx);
         end
      end
   end

   // Reset masks the write path so a beat in flight never reaches the FIFO.
   assign w_in_grant = (r_state == S_GRANT) && !RST;
   assign w_req_v    = bus.req_valid[r_grant_id];
   assign w_write    = w_in_grant && w_req_v && !bus.fifo_full;
   assign w_next_ptr = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;

   assign bus.fifo_write = w_write;
   assign bus.req_ready  = w_write ? (NREQ'(1) << r_grant_id) : '0;
   assign bus.fifo_wdata = w_in_grant ? bus.req_data[r_grant_id*DW +: DW] : '0;
   assign bus.grant_id   = r_grant_id;
   assign bus.busy       = (r_state == S_GRANT);

   assign o_dbg_state    = r_state;
   assign o_dbg_rr_ptr   = r_rr_ptr;
   assign o_dbg_beat_cnt = r_beat_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_grant_id <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant_id <= w_sel;
                  r_beat_cnt <= '0;
                  r_state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (!w_req_v) begin
                  r_state  <= S_IDLE;
                  r_rr_ptr <= w_next_ptr;
               end else if (w_write) begin
                  r_beat_cnt <= r_beat_cnt + 4'd1;
                  if (r_beat_cnt == 4'(BURST - 1)) begin
                     r_state  <= S_IDLE;
                     r_rr_ptr <= w_next_ptr;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Directed bench for sfifo_wr_arbiter: producer lanes modelled as beat counters, cycle expectations written by hand.
module tb_sfifo_wr_arbiter;
   localparam int NREQ  = 3;
   localparam int DW    = 8;
   localparam int BURST = 4;
   localparam int IDW   = 2;

   logic CLK;
   logic RST;
   logic [0:0]     dbg_state;
   logic [IDW-1:0] dbg_rr;
   logic [3:0]     dbg_beat;

   sfifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

   sfifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST), .IDW(IDW)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .bus            (bus),
      .o_dbg_state    (dbg_state),
      .o_dbg_rr_ptr   (dbg_rr),
      .o_dbg_beat_cnt (dbg_beat)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Producer model: rem[i] beats still to send, nxt[i] is the data of the current beat.
   int          rem [NREQ];
   logic [7:0]  nxt [NREQ];
   logic [7:0]  base [NREQ] = '{8'h10, 8'h50, 8'h90};

   logic            s_write;
   logic [DW-1:0]   s_wdata;
   logic [NREQ-1:0] s_ready;
   logic            s_busy;
   logic [IDW-1:0]  s_gid;
   logic [0:0]      s_state;
   logic [IDW-1:0]  s_rr;
   logic [3:0]      s_beat;

   task automatic tick;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]          = (rem[i] != 0);
         bus.req_data[i*DW +: DW]  = nxt[i];
      end
      #4;
      s_write = bus.fifo_write;
      s_wdata = bus.fifo_wdata;
      s_ready = bus.req_ready;
      s_busy  = bus.busy;
      s_gid   = bus.grant_id;
      s_state = dbg_state;
      s_rr    = dbg_rr;
      s_beat  = dbg_beat;
      @(posedge CLK);
      for (int i = 0; i < NREQ; i++) begin
         if (s_ready[i]) begin
            rem[i] = rem[i] - 1;
            nxt[i] = nxt[i] + 8'd1;
         end
      end
      #1;
   endtask

   task automatic do_reset;
      RST = 1'b1;
      bus.fifo_full = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         rem[i] = 0;
         nxt[i] = base[i];
      end
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      bus.fifo_full = 1'b0;
      rem[0] = 5;
      nxt[0] = base[0];
      tick();
      n_tests++;
      if (s_write !== 1'b0 || s_ready !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_gate: write=%b ready=%b want 0/000", s_write, s_ready);
      end
      tick();
      n_tests++;
      if (s_busy !== 1'b0 || s_state !== 1'b0 || s_rr !== 2'd0 || s_beat !== 4'd0 || s_gid !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b st=%b rr=%0d beat=%0d gid=%0d want all 0", s_busy, s_state, s_rr, s_beat, s_gid);
      end
      n_tests++;
      if (s_wdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_wdata: got %h want 00", s_wdata);
      end
   endtask

   task automatic test_single_burst;
      logic       exp_w [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0] exp_d [9] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15, 8'h00};
      do_reset();
      rem[0] = 6;
      for (int c = 0; c < 9; c++) begin
         tick();
         n_tests++;
         if (s_write !== exp_w[c] || s_ready !== (exp_w[c] ? 3'b001 : 3'b000)) begin
            n_fail++;
            $display("FAIL burst_write c%0d: write=%b ready=%b want %b", c, s_write, s_ready, exp_w[c]);
         end
         if (exp_w[c] || c == 0 || c == 5) begin
            n_tests++;
            if (s_wdata !== exp_d[c]) begin
               n_fail++;
               $display("FAIL burst_data c%0d: got %h want %h", c, s_wdata, exp_d[c]);
            end
         end
         if (c == 5) begin
            n_tests++;
            if (s_rr !== 2'd1 || s_busy !== 1'b0) begin
               n_fail++;
               $display("FAIL burst_release: rr=%0d busy=%b want 1/0", s_rr, s_busy);
            end
         end
      end
   endtask

   task automatic test_contention;
      int k;
      int b;
      logic [IDW-1:0] g;
      logic [7:0]     d;
      do_reset();
      for (int i = 0; i < NREQ; i++) rem[i] = 100;
      for (int c = 0; c < 25; c++) begin
         tick();
         k = c / 5;
         b = c % 5;
         g = IDW'(k % 3);
         n_tests++;
         if (s_write !== (b != 0) || s_busy !== (b != 0)) begin
            n_fail++;
            $display("FAIL cont_slot c%0d: write=%b busy=%b want %b", c, s_write, s_busy, (b != 0));
         end
         if (b != 0) begin
            d = base[g] + 8'(4 * (k / 3) + b - 1);
            n_tests++;
            if (s_gid !== g || s_wdata !== d || s_ready !== (3'b001 << g)) begin
               n_fail++;
               $display("FAIL cont_beat c%0d: gid=%0d data=%h ready=%b want %0d/%h", c, s_gid, s_wdata, s_ready, g, d);
            end
         end else if (c > 0) begin
            n_tests++;
            if (s_rr !== IDW'(k % 3)) begin
               n_fail++;
               $display("FAIL cont_rr c%0d: got %0d want %0d", c, s_rr, k % 3);
            end
         end
      end
   endtask

   task automatic test_full_stall;
      logic       exp_w;
      logic [7:0] exp_d [9] = '{8'h00, 8'h50, 8'h51, 8'h00, 8'h00, 8'h00, 8'h52, 8'h53, 8'h00};
      do_reset();
      rem[1] = 4;
      for (int c = 0; c < 9; c++) begin
         bus.fifo_full = (c >= 3 && c <= 5);
         tick();
         exp_w = (c == 1 || c == 2 || c == 6 || c == 7);
         n_tests++;
         if (s_write !== exp_w || s_ready !== (exp_w ? 3'b010 : 3'b000)) begin
            n_fail++;
            $display("FAIL stall_write c%0d: write=%b ready=%b want %b", c, s_write, s_ready, exp_w);
         end
         if (exp_w) begin
            n_tests++;
            if (s_wdata !== exp_d[c]) begin
               n_fail++;
               $display("FAIL stall_data c%0d: got %h want %h", c, s_wdata, exp_d[c]);
            end
         end
         if (c >= 3 && c <= 5) begin
            n_tests++;
            if (s_beat !== 4'd2 || s_gid !== 2'd1 || s_busy !== 1'b1) begin
               n_fail++;
               $display("FAIL stall_hold c%0d: beat=%0d gid=%0d busy=%b want 2/1/1", c, s_beat, s_gid, s_busy);
            end
         end
      end
      n_tests++;
      if (s_busy !== 1'b0 || s_rr !== 2'd2) begin
         n_fail++;
         $display("FAIL stall_release: busy=%b rr=%0d want 0/2", s_busy, s_rr);
      end
      bus.fifo_full = 1'b0;
   endtask

   task automatic test_withdrawal;
      do_reset();
      rem[2] = 1;
      tick();
      rem[0] = 2;
      tick();
      n_tests++;
      if (s_gid !== 2'd2 || s_write !== 1'b1 || s_wdata !== 8'h90 || s_ready !== 3'b100) begin
         n_fail++;
         $display("FAIL wd_beat: gid=%0d write=%b data=%h ready=%b want 2/1/90/100", s_gid, s_write, s_wdata, s_ready);
      end
      tick();
      n_tests++;
      if (s_busy !== 1'b1 || s_write !== 1'b0 || s_ready !== 3'b000) begin
         n_fail++;
         $display("FAIL wd_drop: busy=%b write=%b ready=%b want 1/0/000", s_busy, s_write, s_ready);
      end
      tick();
      n_tests++;
      if (s_busy !== 1'b0 || s_rr !== 2'd0) begin
         n_fail++;
         $display("FAIL wd_release: busy=%b rr=%0d want 0/0", s_busy, s_rr);
      end
      tick();
      n_tests++;
      if (s_gid !== 2'd0 || s_write !== 1'b1 || s_wdata !== 8'h10) begin
         n_fail++;
         $display("FAIL wd_next: gid=%0d write=%b data=%h want 0/1/10", s_gid, s_write, s_wdata);
      end
   endtask

   task automatic test_mid_reset;
      do_reset();
      rem[1] = 10;
      tick();
      tick();
      n_tests++;
      if (s_write !== 1'b1 || s_wdata !== 8'h50 || s_gid !== 2'd1) begin
         n_fail++;
         $display("FAIL mr_beat1: write=%b data=%h gid=%0d want 1/50/1", s_write, s_wdata, s_gid);
      end
      RST = 1'b1;
      rem[0] = 5;
      tick();
      n_tests++;
      if (s_write !== 1'b0 || s_ready !== 3'b000) begin
         n_fail++;
         $display("FAIL mr_gate: write=%b ready=%b want 0/000", s_write, s_ready);
      end
      RST = 1'b0;
      tick();
      n_tests++;
      if (s_busy !== 1'b0 || s_rr !== 2'd0 || s_beat !== 4'd0 || s_state !== 1'b0) begin
         n_fail++;
         $display("FAIL mr_after: busy=%b rr=%0d beat=%0d st=%b want all 0", s_busy, s_rr, s_beat, s_state);
      end
      tick();
      n_tests++;
      if (s_gid !== 2'd0 || s_write !== 1'b1 || s_wdata !== 8'h10 || s_ready !== 3'b001) begin
         n_fail++;
         $display("FAIL mr_regrant: gid=%0d write=%b data=%h ready=%b want 0/1/10/001", s_gid, s_write, s_wdata, s_ready);
      end
   endtask

   task automatic test_sparse;
      do_reset();
      rem[2] = 2;
      tick();
      n_tests++;
      if (s_busy !== 1'b0 || s_rr !== 2'd0 || s_write !== 1'b0) begin
         n_fail++;
         $display("FAIL sparse_idle: busy=%b rr=%0d write=%b want 0/0/0", s_busy, s_rr, s_write);
      end
      tick();
      n_tests++;
      if (s_gid !== 2'd2 || s_write !== 1'b1 || s_wdata !== 8'h90 || s_ready !== 3'b100) begin
         n_fail++;
         $display("FAIL sparse_grant: gid=%0d write=%b data=%h ready=%b want 2/1/90/100", s_gid, s_write, s_wdata, s_ready);
      end
   endtask

   initial begin
      RST           = 1'b1;
      bus.fifo_full = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         rem[i] = 0;
         nxt[i] = base[i];
      end
      @(posedge CLK);
      #1;
      test_reset();
      test_single_burst();
      test_contention();
      test_full_stall();
      test_withdrawal();
      test_mid_reset();
      test_sparse();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
